// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage RV32 core.
// Drives a synchronous instruction memory (data one cycle after address) and absorbs stalls/redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic [31:0] redirect_addr;

  assign redirect_addr = {redirect_pc[31:2], 2'b00};

  // NOTE: every output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    im_req  = 1'b1;
    im_addr = pc_q;
    if (rst) begin
      im_req = 1'b0;
    end else if (redirect) begin
      im_addr = redirect_addr;
    end else if (stall) begin
      // Re-read the pending word so im_rdata is still valid when the stall lifts.
      im_req  = pend_valid;
      im_addr = pend_pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC_ALIGNED;
      pend_valid  <= 1'b0;
      pend_pc     <= RESET_PC_ALIGNED;
      if_id_inst  <= NOP_INST;
      if_id_pc    <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      // The in-flight word belongs to the wrong path; drop it and insert a bubble.
      pc_q        <= redirect_addr + 32'd4;
      pend_valid  <= 1'b1;
      pend_pc     <= redirect_addr;
      if_id_inst  <= NOP_INST;
      if_id_pc    <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc_q       <= pc_q + 32'd4;
      pend_valid <= 1'b1;
      pend_pc    <= pc_q;
      if (pend_valid) begin
        if_id_inst  <= im_rdata;
        if_id_pc    <= pend_pc;
        if_id_valid <= 1'b1;
      end else begin
        if_id_inst  <= NOP_INST;
        if_id_pc    <= 32'h0;
        if_id_valid <= 1'b0;
      end
    end
  end

endmodule
